// File: rtl/fpnew_seq_adapter_if.sv
// Request/response and core-side bundle for fpnew_seq_adapter.
// The adapter binds the slave modport; the requester/core environment binds master.
interface fpnew_seq_adapter_if #(
    parameter int WIDTH     = 64,
    parameter int TAG_WIDTH = 8
);
    logic [3*WIDTH-1:0]   operands_i;
    logic [2:0]           rnd_mode_i;
    logic [3:0]           op_i;
    logic                 op_mod_i;
    logic [2:0]           src_fmt_i;
    logic [2:0]           dst_fmt_i;
    logic [1:0]           int_fmt_i;
    logic [TAG_WIDTH-1:0] tag_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic                 flush_i;
    logic [WIDTH-1:0]     result_o;
    logic [4:0]           status_o;
    logic [TAG_WIDTH-1:0] tag_o;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic                 busy_o;
    logic                 core_enable_o;
    logic [4:0]           core_op_o;
    logic [WIDTH-1:0]     core_opa_o;
    logic [WIDTH-1:0]     core_opb_o;
    logic [WIDTH-1:0]     core_opc_o;
    logic [2:0]           core_rnd_o;
    logic [2:0]           core_src_fmt_o;
    logic [2:0]           core_dst_fmt_o;
    logic [1:0]           core_int_fmt_o;
    logic                 core_ready_i;
    logic [WIDTH-1:0]     core_result_i;
    logic [4:0]           core_status_i;

    modport slave (
        input  operands_i, rnd_mode_i, op_i, op_mod_i, src_fmt_i, dst_fmt_i, int_fmt_i,
               tag_i, in_valid_i, flush_i, out_ready_i, core_ready_i, core_result_i,
               core_status_i,
        output in_ready_o, result_o, status_o, tag_o, out_valid_o, busy_o, core_enable_o,
               core_op_o, core_opa_o, core_opb_o, core_opc_o, core_rnd_o, core_src_fmt_o,
               core_dst_fmt_o, core_int_fmt_o
    );

    modport master (
        output operands_i, rnd_mode_i, op_i, op_mod_i, src_fmt_i, dst_fmt_i, int_fmt_i,
               tag_i, in_valid_i, flush_i, out_ready_i, core_ready_i, core_result_i,
               core_status_i,
        input  in_ready_o, result_o, status_o, tag_o, out_valid_o, busy_o, core_enable_o,
               core_op_o, core_opa_o, core_opb_o, core_opc_o, core_rnd_o, core_src_fmt_o,
               core_dst_fmt_o, core_int_fmt_o
    );
endinterface

// File: rtl/fpnew_seq_adapter.sv
// Sequential adapter: queues FP requests, issues them one at a time to a core, queues results.
// Optional watchdog enabled by defining FPNEW_SEQ_ADAPTER_TIMEOUT_EN.
module fpnew_seq_adapter #(
    parameter int WIDTH          = 64,
    parameter int TAG_WIDTH      = 8,
    parameter int IN_DEPTH       = 8,
    parameter int OUT_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    fpnew_seq_adapter_if.slave  bus
);
    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int OUT_AW = $clog2(OUT_DEPTH);

    typedef enum logic { ST_IDLE, ST_BUSY } state_t;

    typedef struct packed {
        logic [WIDTH-1:0]     opc;
        logic [WIDTH-1:0]     opb;
        logic [WIDTH-1:0]     opa;
        logic [2:0]           rnd;
        logic [4:0]           op;
        logic [2:0]           src_fmt;
        logic [2:0]           dst_fmt;
        logic [1:0]           int_fmt;
        logic [TAG_WIDTH-1:0] tag;
    } req_t;

    typedef struct packed {
        logic [WIDTH-1:0]     result;
        logic [4:0]           status;
        logic [TAG_WIDTH-1:0] tag;
    } rsp_t;

    // Core opcode translation is done once at enqueue so the issue path stays short.
    function automatic logic [4:0] map_op(input logic [3:0] op, input logic mod);
        logic [4:0] base;
        base = 5'd0;
        case (op)
            4'd0:  base = mod ? 5'd5 : 5'd4;
            4'd1:  base = mod ? 5'd4 : 5'd13;
            4'd2:  base = mod ? 5'd1 : 5'd0;
            4'd3:  base = 5'd6;
            4'd4:  base = 5'd3;
            4'd5:  base = 5'd11;
            4'd6:  base = 5'd7;
            4'd7:  base = 5'd25;
            4'd8:  base = 5'd9;
            4'd9:  base = 5'd8;
            4'd10: base = 5'd15;
            4'd11: base = 5'd10;
            4'd12: base = 5'd2;
            default: return 5'd0;
        endcase
        return mod ? (base | 5'h10) : base;
    endfunction

    state_t state_q, state_d;

    req_t                 in_mem_q [IN_DEPTH];
    logic [IN_AW:0]       in_wr_ptr_q, in_wr_ptr_d, in_rd_ptr_q, in_rd_ptr_d;
    rsp_t                 out_mem_q [OUT_DEPTH];
    logic [OUT_AW:0]      out_wr_ptr_q, out_wr_ptr_d, out_rd_ptr_q, out_rd_ptr_d;

    logic                 core_enable_q, core_enable_d;
    logic [4:0]           core_op_q, core_op_d;
    logic [WIDTH-1:0]     core_opa_q, core_opa_d, core_opb_q, core_opb_d, core_opc_q, core_opc_d;
    logic [2:0]           core_rnd_q, core_rnd_d;
    logic [2:0]           core_src_fmt_q, core_src_fmt_d, core_dst_fmt_q, core_dst_fmt_d;
    logic [1:0]           core_int_fmt_q, core_int_fmt_d;
    logic [TAG_WIDTH-1:0] core_tag_q, core_tag_d;
    logic                 core_ready_prev_q;
    logic                 first_q, first_d;

    logic in_empty, in_full, out_empty, out_full;
    logic in_push, in_pop, out_push, out_pop;
    req_t in_wdata, in_head;
    rsp_t out_wdata, out_head;
    logic completion;

    assign in_empty  = (in_wr_ptr_q == in_rd_ptr_q);
    assign in_full   = (in_wr_ptr_q[IN_AW] != in_rd_ptr_q[IN_AW]) &&
                       (in_wr_ptr_q[IN_AW-1:0] == in_rd_ptr_q[IN_AW-1:0]);
    assign out_empty = (out_wr_ptr_q == out_rd_ptr_q);
    assign out_full  = (out_wr_ptr_q[OUT_AW] != out_rd_ptr_q[OUT_AW]) &&
                       (out_wr_ptr_q[OUT_AW-1:0] == out_rd_ptr_q[OUT_AW-1:0]);

    assign in_push = bus.in_valid_i && !in_full && !bus.flush_i;
    assign out_pop = !out_empty && bus.out_ready_i && !bus.flush_i;

    assign in_head  = in_mem_q[in_rd_ptr_q[IN_AW-1:0]];
    assign out_head = out_mem_q[out_rd_ptr_q[OUT_AW-1:0]];

    always_comb begin
        in_wdata         = '0;
        in_wdata.opa     = bus.operands_i[WIDTH-1:0];
        in_wdata.opb     = bus.operands_i[2*WIDTH-1:WIDTH];
        in_wdata.opc     = bus.operands_i[3*WIDTH-1:2*WIDTH];
        in_wdata.rnd     = bus.rnd_mode_i;
        in_wdata.op      = map_op(bus.op_i, bus.op_mod_i);
        in_wdata.src_fmt = bus.src_fmt_i;
        in_wdata.dst_fmt = bus.dst_fmt_i;
        in_wdata.int_fmt = bus.int_fmt_i;
        in_wdata.tag     = bus.tag_i;
    end

    // A rising core_ready_i in the first BUSY cycle may belong to the previous op; ignore it.
    assign completion = (state_q == ST_BUSY) && !first_q &&
                        bus.core_ready_i && !core_ready_prev_q;

`ifdef FPNEW_SEQ_ADAPTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] timeout_cnt_q, timeout_cnt_d;
`endif

    always_comb begin
        state_d        = state_q;
        core_enable_d  = core_enable_q;
        core_op_d      = core_op_q;
        core_opa_d     = core_opa_q;
        core_opb_d     = core_opb_q;
        core_opc_d     = core_opc_q;
        core_rnd_d     = core_rnd_q;
        core_src_fmt_d = core_src_fmt_q;
        core_dst_fmt_d = core_dst_fmt_q;
        core_int_fmt_d = core_int_fmt_q;
        core_tag_d     = core_tag_q;
        first_d        = 1'b0;
        in_pop         = 1'b0;
        out_push       = 1'b0;
        out_wdata      = '0;
`ifdef FPNEW_SEQ_ADAPTER_TIMEOUT_EN
        timeout_cnt_d  = timeout_cnt_q;
`endif
        if (bus.flush_i) begin
            state_d       = ST_IDLE;
            core_enable_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!in_empty && !out_full) begin
                        in_pop         = 1'b1;
                        state_d        = ST_BUSY;
                        core_enable_d  = 1'b1;
                        first_d        = 1'b1;
                        core_op_d      = in_head.op;
                        core_opa_d     = in_head.opa;
                        core_opb_d     = in_head.opb;
                        core_opc_d     = in_head.opc;
                        core_rnd_d     = in_head.rnd;
                        core_src_fmt_d = in_head.src_fmt;
                        core_dst_fmt_d = in_head.dst_fmt;
                        core_int_fmt_d = in_head.int_fmt;
                        core_tag_d     = in_head.tag;
`ifdef FPNEW_SEQ_ADAPTER_TIMEOUT_EN
                        timeout_cnt_d  = '0;
`endif
                    end
                end
                ST_BUSY: begin
                    if (completion) begin
                        out_push         = 1'b1;
                        out_wdata.result = bus.core_result_i;
                        out_wdata.status = bus.core_status_i;
                        out_wdata.tag    = core_tag_q;
                        core_enable_d    = 1'b0;
                        state_d          = ST_IDLE;
                    end
`ifdef FPNEW_SEQ_ADAPTER_TIMEOUT_EN
                    else if (timeout_cnt_q == TO_LIMIT) begin
                        out_push         = 1'b1;
                        out_wdata.status = 5'b10000;
                        out_wdata.tag    = core_tag_q;
                        core_enable_d    = 1'b0;
                        state_d          = ST_IDLE;
                    end else begin
                        timeout_cnt_d = timeout_cnt_q + 1'b1;
                    end
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Result space was reserved at issue, so out_push never meets a full result queue.
    always_comb begin
        in_wr_ptr_d  = in_wr_ptr_q + {{IN_AW{1'b0}}, in_push};
        in_rd_ptr_d  = in_rd_ptr_q + {{IN_AW{1'b0}}, in_pop};
        out_wr_ptr_d = out_wr_ptr_q + {{OUT_AW{1'b0}}, out_push};
        out_rd_ptr_d = out_rd_ptr_q + {{OUT_AW{1'b0}}, out_pop};
        if (bus.flush_i) begin
            in_wr_ptr_d  = '0;
            in_rd_ptr_d  = '0;
            out_wr_ptr_d = '0;
            out_rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q           <= ST_IDLE;
            in_wr_ptr_q       <= '0;
            in_rd_ptr_q       <= '0;
            out_wr_ptr_q      <= '0;
            out_rd_ptr_q      <= '0;
            core_enable_q     <= 1'b0;
            core_op_q         <= '0;
            core_opa_q        <= '0;
            core_opb_q        <= '0;
            core_opc_q        <= '0;
            core_rnd_q        <= '0;
            core_src_fmt_q    <= '0;
            core_dst_fmt_q    <= '0;
            core_int_fmt_q    <= '0;
            core_tag_q        <= '0;
            core_ready_prev_q <= 1'b0;
            first_q           <= 1'b0;
        end else begin
            state_q           <= state_d;
            in_wr_ptr_q       <= in_wr_ptr_d;
            in_rd_ptr_q       <= in_rd_ptr_d;
            out_wr_ptr_q      <= out_wr_ptr_d;
            out_rd_ptr_q      <= out_rd_ptr_d;
            core_enable_q     <= core_enable_d;
            core_op_q         <= core_op_d;
            core_opa_q        <= core_opa_d;
            core_opb_q        <= core_opb_d;
            core_opc_q        <= core_opc_d;
            core_rnd_q        <= core_rnd_d;
            core_src_fmt_q    <= core_src_fmt_d;
            core_dst_fmt_q    <= core_dst_fmt_d;
            core_int_fmt_q    <= core_int_fmt_d;
            core_tag_q        <= core_tag_d;
            core_ready_prev_q <= bus.core_ready_i;
            first_q           <= first_d;
        end
    end

`ifdef FPNEW_SEQ_ADAPTER_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) timeout_cnt_q <= '0;
        else         timeout_cnt_q <= timeout_cnt_d;
    end
`endif

    // Queue storage carries no reset; validity is tracked purely by the pointers.
    always_ff @(posedge clk_i) begin
        if (in_push)  in_mem_q[in_wr_ptr_q[IN_AW-1:0]]    <= in_wdata;
        if (out_push) out_mem_q[out_wr_ptr_q[OUT_AW-1:0]] <= out_wdata;
    end

    assign bus.in_ready_o     = !in_full;
    assign bus.out_valid_o    = !out_empty;
    assign bus.result_o       = out_empty ? '0 : out_head.result;
    assign bus.status_o       = out_empty ? '0 : out_head.status;
    assign bus.tag_o          = out_empty ? '0 : out_head.tag;
    assign bus.busy_o         = (state_q == ST_BUSY) || !in_empty || !out_empty;
    assign bus.core_enable_o  = core_enable_q;
    assign bus.core_op_o      = core_op_q;
    assign bus.core_opa_o     = core_opa_q;
    assign bus.core_opb_o     = core_opb_q;
    assign bus.core_opc_o     = core_opc_q;
    assign bus.core_rnd_o     = core_rnd_q;
    assign bus.core_src_fmt_o = core_src_fmt_q;
    assign bus.core_dst_fmt_o = core_dst_fmt_q;
    assign bus.core_int_fmt_o = core_int_fmt_q;
endmodule

// File: tb/tb_fpnew_seq_adapter.sv
// Directed self-checking bench for fpnew_seq_adapter.
module tb_fpnew_seq_adapter;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    fpnew_seq_adapter_if #(.WIDTH(64), .TAG_WIDTH(8)) bus ();

    fpnew_seq_adapter #(
        .WIDTH(64), .TAG_WIDTH(8), .IN_DEPTH(8), .OUT_DEPTH(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] tag, input logic [3:0] op, input logic mod,
                        input logic [63:0] opa);
        bus.operands_i = {64'hC, 64'hB, opa};
        bus.op_i       = op;
        bus.op_mod_i   = mod;
        bus.tag_i      = tag;
        bus.in_valid_i = 1'b1;
        step();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic wait_enable(input int limit);
        int n;
        n = 0;
        while (!bus.core_enable_o && n < limit) begin
            step();
            n++;
        end
        chk("wait_core_enable", bus.core_enable_o, 1'b1);
    endtask

    // Emulated core: answers opa+1 with status opa[4:0], two cycles after enable.
    task automatic serve_one();
        wait_enable(50);
        step();
        step();
        bus.core_result_i = bus.core_opa_o + 64'd1;
        bus.core_status_i = bus.core_opa_o[4:0];
        bus.core_ready_i  = 1'b1;
        step();
        bus.core_ready_i  = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] op, input logic mod, input logic [4:0] exp_op);
        push(8'h70, op, mod, 64'h7);
        wait_enable(20);
        chk("core_op_map", bus.core_op_o, exp_op);
        step();
        bus.core_ready_i = 1'b1;
        step();
        bus.core_ready_i = 1'b0;
        chk("op_out_valid", bus.out_valid_o, 1'b1);
        step();
        chk("op_busy_after", bus.busy_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        checks = 0;
        failures = 0;
        bus.operands_i = '0; bus.rnd_mode_i = 3'd1; bus.op_i = '0; bus.op_mod_i = 1'b0;
        bus.src_fmt_i = 3'd0; bus.dst_fmt_i = 3'd0; bus.int_fmt_i = 2'd0; bus.tag_i = '0;
        bus.in_valid_i = 1'b0; bus.flush_i = 1'b0; bus.out_ready_i = 1'b0;
        bus.core_ready_i = 1'b0; bus.core_result_i = '0; bus.core_status_i = '0;
        rst_n = 1'b0;
        step();
        step();
        chk("rst_out_valid", bus.out_valid_o, 1'b0);
        chk("rst_core_enable", bus.core_enable_o, 1'b0);
        chk("rst_core_op", bus.core_op_o, 5'd0);
        chk("rst_core_opa", bus.core_opa_o, 64'd0);
        chk("rst_result", bus.result_o, 64'd0);
        chk("rst_tag", bus.tag_o, 8'd0);
        chk("rst_busy", bus.busy_o, 1'b0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", bus.in_ready_o, 1'b1);

        // Single ADD, core_ready rising five cycles after enable
        push(8'h11, 4'd2, 1'b0, 64'h3FF0);
        chk("add_enable_T", bus.core_enable_o, 1'b0);
        step();
        chk("add_enable_T1", bus.core_enable_o, 1'b1);
        chk("add_core_op", bus.core_op_o, 5'd0);
        chk("add_core_opa", bus.core_opa_o, 64'h3FF0);
        chk("add_core_opb", bus.core_opb_o, 64'hB);
        chk("add_core_rnd", bus.core_rnd_o, 3'd1);
        for (int i = 0; i < 4; i++) step();
        chk("add_no_valid_early", bus.out_valid_o, 1'b0);
        bus.core_result_i = 64'h4000;
        bus.core_status_i = 5'b00001;
        bus.core_ready_i  = 1'b1;
        step();
        bus.core_ready_i  = 1'b0;
        chk("add_out_valid", bus.out_valid_o, 1'b1);
        chk("add_result", bus.result_o, 64'h4000);
        chk("add_status", bus.status_o, 5'b00001);
        chk("add_tag", bus.tag_o, 8'h11);
        chk("add_enable_drop", bus.core_enable_o, 1'b0);
        bus.out_ready_i = 1'b1;
        step();
        bus.out_ready_i = 1'b0;
        chk("add_popped", bus.out_valid_o, 1'b0);
        chk("add_idle_busy", bus.busy_o, 1'b0);

        // Backpressure: six requests, result queue holds four
        for (int i = 0; i < 6; i++) push(8'h20 + 8'(i), 4'd3, 1'b0, 64'h1000 + 64'(i));
        for (int i = 0; i < 4; i++) serve_one();
        chk("bp_out_valid", bus.out_valid_o, 1'b1);
        for (int i = 0; i < 5; i++) step();
        chk("bp_no_fifth_issue", bus.core_enable_o, 1'b0);
        chk("bp_head_stable", bus.tag_o, 8'h20);
        chk("bp_busy", bus.busy_o, 1'b1);
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_drain_valid", bus.out_valid_o, 1'b1);
            chk("bp_drain_tag", bus.tag_o, 8'h20 + 8'(i));
            chk("bp_drain_result", bus.result_o, 64'h1001 + 64'(i));
            chk("bp_drain_status", bus.status_o, 5'(i));
            step();
        end
        for (int i = 4; i < 6; i++) begin
            serve_one();
            chk("bp_tail_valid", bus.out_valid_o, 1'b1);
            chk("bp_tail_tag", bus.tag_o, 8'h20 + 8'(i));
            chk("bp_tail_result", bus.result_o, 64'h1001 + 64'(i));
        end
        step();
        chk("bp_done_valid", bus.out_valid_o, 1'b0);
        chk("bp_done_busy", bus.busy_o, 1'b0);

        // Input queue full: one in flight plus eight queued
        for (int i = 0; i < 9; i++) begin
            chk("full_ready_before", bus.in_ready_o, 1'b1);
            push(8'h40 + 8'(i), 4'd2, 1'b0, 64'h2000 + 64'(i));
        end
        chk("full_ready_after", bus.in_ready_o, 1'b0);
        bus.tag_i = 8'h99;
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) step();
        bus.in_valid_i = 1'b0;
        chk("full_ready_held", bus.in_ready_o, 1'b0);
        chk("full_in_flight", bus.core_enable_o, 1'b1);

        // Flush wins over a same-cycle completion
        bus.flush_i = 1'b1;
        bus.core_ready_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        bus.core_ready_i = 1'b0;
        chk("flush_enable", bus.core_enable_o, 1'b0);
        chk("flush_out_valid", bus.out_valid_o, 1'b0);
        chk("flush_busy", bus.busy_o, 1'b0);
        chk("flush_in_ready", bus.in_ready_o, 1'b1);
        step();
        chk("flush_no_reissue", bus.core_enable_o, 1'b0);

        // Opcode mapping
        run_op(4'd0, 1'b1, 5'd21);
        run_op(4'd1, 1'b0, 5'd13);
        run_op(4'd7, 1'b0, 5'd25);
        run_op(4'd3, 1'b1, 5'd22);
        bus.out_ready_i = 1'b0;

        // Reset in the middle of work discards everything
        push(8'h60, 4'd2, 1'b0, 64'h1);
        push(8'h61, 4'd2, 1'b0, 64'h2);
        push(8'h62, 4'd2, 1'b0, 64'h3);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", bus.busy_o, 1'b0);
        chk("midrst_enable", bus.core_enable_o, 1'b0);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("midrst_out_valid", bus.out_valid_o, 1'b0);
        chk("midrst_no_issue", bus.core_enable_o, 1'b0);

`ifdef FPNEW_SEQ_ADAPTER_TIMEOUT_EN
        // Watchdog with core_ready held low
        push(8'h51, 4'd2, 1'b0, 64'h5);
        push(8'h52, 4'd2, 1'b0, 64'h6);
        wait_enable(5);
        for (int i = 0; i < 15; i++) step();
        chk("to_not_yet", bus.out_valid_o, 1'b0);
        step();
        chk("to_out_valid", bus.out_valid_o, 1'b1);
        chk("to_result", bus.result_o, 64'd0);
        chk("to_status", bus.status_o, 5'b10000);
        chk("to_tag", bus.tag_o, 8'h51);
        chk("to_enable_drop", bus.core_enable_o, 1'b0);
        step();
        chk("to_next_issue", bus.core_enable_o, 1'b1);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fpnew_seq_adapter.md
FPNEW_SEQ_ADAPTER -- requirements
Module: fpnew_seq_adapter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  WIDTH 64, operand/result width;
  TAG_WIDTH 8, tag width;
  IN_DEPTH 8, input queue entries (power of 2, >=2);
  OUT_DEPTH 4, result queue entries (power of 2, >=2);
  TIMEOUT_CYCLES 256, watchdog limit.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk_i in 1 clock;
  rst_ni in 1 reset;
  operands_i in 3*WIDTH {c,b,a};
  rnd_mode_i in 3;
  op_i in 4 (0..12 = FMADD,FNMSUB,ADD,MUL,DIV,SQRT,SGNJ,MINMAX,CMP,CLASSIFY,F2F,F2I,I2F);
  op_mod_i in 1;
  src_fmt_i in 3; dst_fmt_i in 3; int_fmt_i in 2;
  tag_i in TAG_WIDTH;
  in_valid_i in 1; in_ready_o out 1;
  flush_i in 1;
  result_o out WIDTH; status_o out 5 {NV,DZ,OF,UF,NX}; tag_o out TAG_WIDTH;
  out_valid_o out 1; out_ready_i in 1;
  busy_o out 1;
  core_enable_o out 1; core_op_o out 5;
  core_opa_o, core_opb_o, core_opc_o out WIDTH each;
  core_rnd_o out 3; core_src_fmt_o out 3; core_dst_fmt_o out 3; core_int_fmt_o out 2;
  core_ready_i in 1; core_result_i in WIDTH; core_status_i in 5.
REQ-003 One clock, clk_i; reset rst_ni SHALL be asynchronous, active-low.

Function
REQ-004 Input handshake: request SHALL be written to the input queue on a clock edge where in_valid_i && in_ready_o; in_ready_o = input queue not full.
REQ-005 FSM states SHALL be IDLE and BUSY.
REQ-006 IDLE->BUSY SHALL occur when the input queue is non-empty and the result queue has a free entry: pop head, latch its fields onto the core_* outputs, assert core_enable_o from the next cycle.
REQ-007 core_op_o mapping (op_mod 0/1) SHALL be:
  FMADD 4/5; FNMSUB 13/4; ADD 0/1; MUL 6; DIV 3; SQRT 11; SGNJ 7; MINMAX 25; CMP 9; CLASSIFY 8; F2F 15; F2I 10; I2F 2;
  op_mod=1 additionally sets bit4; op_i >12 maps to 0.
REQ-008 Completion in BUSY SHALL be a rising edge of core_ready_i (core_ready_i=1, registered previous value=0), ignored in the first BUSY cycle.
REQ-009 On completion the block SHALL write {core_result_i, core_status_i, latched tag} into the result queue, deassert core_enable_o, and return to IDLE; IDLE->BUSY SHALL be possible on the very next edge.
REQ-010 Latency: request accepted at edge T into an empty idle block -> core_enable_o=1 after edge T+1; completion sampled at edge C -> out_valid_o=1 after edge C.
REQ-011 Output handshake: result queue head SHALL drive result_o/status_o/tag_o with out_valid_o = not empty; pop on out_valid_o && out_ready_i; held stable while out_ready_i=0.
REQ-012 Simultaneous push and pop on a full input queue SHALL NOT be accepted (in_ready_o=0); simultaneous push/pop on either queue when not full/empty SHALL keep the count unchanged.
REQ-013 flush_i=1 SHALL, at the next edge: empty both queues, deassert core_enable_o, go IDLE, discard the in-flight op; flush SHALL take priority over same-cycle push, pop and completion.
REQ-014 Results SHALL leave in issue order; exactly one result per accepted, non-flushed request.
REQ-015 busy_o SHALL be 1 when state=BUSY or either queue is non-empty.

Reset
REQ-016 Under rst_ni=0 the block SHALL set: state IDLE, queues empty, out_valid_o=0, core_enable_o=0, core_op_o=0, all core operand/format outputs 0, result_o/status_o/tag_o=0, busy_o=0; in_ready_o=1 after release.
REQ-017 Reset asserted mid-operation SHALL discard all queued and in-flight work without emitting a result.

Configuration
REQ-018 Macro FPNEW_SEQ_ADAPTER_TIMEOUT_EN, when defined, SHALL add a cycle counter cleared on IDLE->BUSY.
REQ-019 With the macro defined, if no completion occurs within TIMEOUT_CYCLES BUSY cycles, the block SHALL write result 0, status NV=1 (others 0) and the latched tag, deassert core_enable_o, and go IDLE.
REQ-020 Without the macro, the counter SHALL NOT exist and BUSY SHALL wait indefinitely.

Verification
REQ-021 Single ADD: op_i=2, op_mod=0, tag 0x11, core_ready rises 5 cycles after enable -> core_op_o=0; out_valid_o one cycle after the rise; tag_o=0x11.
REQ-022 Backpressure: 6 back-to-back requests, out_ready_i=0 -> at most OUT_DEPTH=4 results buffered; no 5th issue; all 6 delivered in order once out_ready_i=1.
REQ-023 Input full: 9 requests, core stalled -> in_ready_o=0 after the 9th accepted request (1 in flight + 8 queued).
REQ-024 Flush in BUSY with 3 queued -> core_enable_o=0 next cycle, out_valid_o stays 0, busy_o=0.
REQ-025 FMADD with op_mod=1 -> core_op_o=21; FNMSUB with op_mod=0 -> 13.
REQ-026 Macro defined, TIMEOUT_CYCLES=16, core_ready_i held 0 -> result 0, status_o=5'b10000 after 16 BUSY cycles, next request issued.
